// File: rtl/tile_fetch.sv
// -----------------------------------------------------------------------------
// tile_fetch
//
// Sits between the VGA timing counters and draw_sprite. Holds the tile map
// (one 16-bit sprite word per tile), turns the current scan position into a
// tile coordinate plus in-tile pixel offsets, and fetches that tile's sprite
// word through a two-stage pipeline (counters -> outputs in 2 cycles).
// Game logic updates tiles through a single write port; a clear sequencer can
// sweep the whole map with one fill value.
//
// Ports:
//   i_Clk        pixel clock
//   i_Rst_n      asynchronous active-low reset (map RAM is not reset)
//   i_Col_Count  current scan column 0..799
//   i_Row_Count  current scan row 0..524
//   i_Active     visible-area flag from the timing generator
//   i_Wr_En      single-cycle tile write request
//   i_Wr_X/Y     tile column/row to write
//   i_Wr_Data    sprite word to write; also the fill value sampled on i_Clear
//   i_Clear      pulse: start a fill sweep over the whole map
//   o_X/o_Y      tile column/row of the pixel (sliced even when not visible)
//   o_Sprite     sprite word of the tile, 0 when not visible
//   o_Local_X/Y  pixel offset inside the tile
//   o_Valid      outputs belong to a visible pixel
//   o_Busy       clear sweep in progress
//   o_Wr_Err     one-cycle pulse: the write of the previous cycle was rejected
// -----------------------------------------------------------------------------
module tile_fetch #(
    parameter int TILE_WIDTH  = 32,
    parameter int TILE_HEIGHT = 32,
    parameter int MAP_COLS    = 20,
    parameter int MAP_ROWS    = 15
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [9:0]  i_Col_Count,
    input  logic [9:0]  i_Row_Count,
    input  logic        i_Active,
    input  logic        i_Wr_En,
    input  logic [4:0]  i_Wr_X,
    input  logic [3:0]  i_Wr_Y,
    input  logic [15:0] i_Wr_Data,
    input  logic        i_Clear,
    output logic [4:0]  o_X,
    output logic [3:0]  o_Y,
    output logic [15:0] o_Sprite,
    output logic [4:0]  o_Local_X,
    output logic [4:0]  o_Local_Y,
    output logic        o_Valid,
    output logic        o_Busy,
    output logic        o_Wr_Err
);

    localparam int LX_W   = $clog2(TILE_WIDTH);
    localparam int LY_W   = $clog2(TILE_HEIGHT);
    localparam int DEPTH  = MAP_COLS * MAP_ROWS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [9:0]        SCREEN_W  = 10'(MAP_COLS * TILE_WIDTH);
    localparam logic [9:0]        SCREEN_H  = 10'(MAP_ROWS * TILE_HEIGHT);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Scan-position decode (feeds stage 1)
    // ------------------------------------------------------------------
    logic [4:0]        tile_col;
    logic [3:0]        tile_row;
    logic [4:0]        local_x;
    logic [4:0]        local_y;
    logic              visible;
    logic [ADDR_W-1:0] scan_addr;

    // Tile sizes are powers of two, so tile index and offset are bit slices.
    // Rows 512..524 wrap the tile row to 0; they are never visible anyway.
    assign tile_col  = 5'(i_Col_Count >> LX_W);
    assign tile_row  = 4'(i_Row_Count >> LY_W);
    assign local_x   = 5'(i_Col_Count & 10'(TILE_WIDTH - 1));
    assign local_y   = 5'(i_Row_Count & 10'(TILE_HEIGHT - 1));
    assign visible   = i_Active && (i_Col_Count < SCREEN_W) && (i_Row_Count < SCREEN_H);
    assign scan_addr = ADDR_W'(tile_row) * ADDR_W'(MAP_COLS) + ADDR_W'(tile_col);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic              s1_valid_reg;
    logic [4:0]        s1_x_reg;
    logic [3:0]        s1_y_reg;
    logic [4:0]        s1_lx_reg;
    logic [4:0]        s1_ly_reg;
    logic [ADDR_W-1:0] s1_addr_reg;

    logic              s2_valid_reg;
    logic [4:0]        s2_x_reg;
    logic [3:0]        s2_y_reg;
    logic [4:0]        s2_lx_reg;
    logic [4:0]        s2_ly_reg;
    logic [15:0]       rd_data_reg;
    logic              wr_err_reg;

    // ------------------------------------------------------------------
    // Clear sequencer state
    // ------------------------------------------------------------------
    state_t            state_reg,    state_next;
    logic [ADDR_W-1:0] clr_addr_reg, clr_addr_next;
    logic [15:0]       fill_reg,     fill_next;

    // ------------------------------------------------------------------
    // Write port arbitration
    // ------------------------------------------------------------------
    logic              wr_in_range;
    logic              wr_accept;
    logic [ADDR_W-1:0] wr_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;

    // Range check happens before the address multiply so that an
    // out-of-range coordinate can never land on a different tile.
    assign wr_in_range = (i_Wr_X < 5'(MAP_COLS)) && (i_Wr_Y < 4'(MAP_ROWS));
    // A clear request in the same IDLE cycle takes priority over a write.
    assign wr_accept   = i_Wr_En && (state_reg == IDLE) && !i_Clear && wr_in_range;
    assign wr_addr     = ADDR_W'(i_Wr_Y) * ADDR_W'(MAP_COLS) + ADDR_W'(i_Wr_X);

    // The sweep owns the RAM write port while clearing; held reset
    // blocks any write so a reset mid-sweep stops exactly where it is.
    assign ram_we    = i_Rst_n && ((state_reg == CLEAR) || wr_accept);
    assign ram_waddr = (state_reg == CLEAR) ? clr_addr_reg : wr_addr;
    assign ram_wdata = (state_reg == CLEAR) ? fill_reg     : i_Wr_Data;

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        fill_next     = fill_reg;
        case (state_reg)
            IDLE: begin
                if (i_Clear) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                    fill_next     = i_Wr_Data;
                end
            end
            CLEAR: begin
                // The last entry is written in this cycle, then back to IDLE.
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    clr_addr_next = clr_addr_reg + ADDR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_reg    <= IDLE;
            clr_addr_reg <= '0;
            fill_reg     <= '0;
            s1_valid_reg <= 1'b0;
            s1_x_reg     <= '0;
            s1_y_reg     <= '0;
            s1_lx_reg    <= '0;
            s1_ly_reg    <= '0;
            s1_addr_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_x_reg     <= '0;
            s2_y_reg     <= '0;
            s2_lx_reg    <= '0;
            s2_ly_reg    <= '0;
            wr_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            fill_reg     <= fill_next;

            s1_valid_reg <= visible;
            s1_x_reg     <= tile_col;
            s1_y_reg     <= tile_row;
            s1_lx_reg    <= local_x;
            s1_ly_reg    <= local_y;
            s1_addr_reg  <= scan_addr;

            s2_valid_reg <= s1_valid_reg;
            s2_x_reg     <= s1_x_reg;
            s2_y_reg     <= s1_y_reg;
            s2_lx_reg    <= s1_lx_reg;
            s2_ly_reg    <= s1_ly_reg;

            wr_err_reg   <= i_Wr_En && !wr_accept;
        end
    end

    // ------------------------------------------------------------------
    // Tile map RAM: one write port, one registered read port, read-first.
    // The read register carries no reset so it maps onto block RAM; the
    // sprite output is instead masked by the (reset) valid flag.
    // ------------------------------------------------------------------
    logic [15:0] map_ram [DEPTH];

    always_ff @(posedge i_Clk) begin
        if (ram_we) begin
            map_ram[ram_waddr] <= ram_wdata;
        end
        rd_data_reg <= map_ram[s1_addr_reg];
    end

    assign o_X       = s2_x_reg;
    assign o_Y       = s2_y_reg;
    assign o_Local_X = s2_lx_reg;
    assign o_Local_Y = s2_ly_reg;
    assign o_Valid   = s2_valid_reg;
    assign o_Sprite  = s2_valid_reg ? rd_data_reg : 16'h0000;
    assign o_Busy    = (state_reg == CLEAR);
    assign o_Wr_Err  = wr_err_reg;

endmodule

// File: tb/tb_tile_fetch.sv
// -----------------------------------------------------------------------------
// tb_tile_fetch
//
// Self-checking bench for tile_fetch. A plain array holds the expected map;
// expected tile coordinates come from division/modulo on the scan position.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tile_fetch;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n;
    logic [9:0]  i_Col_Count;
    logic [9:0]  i_Row_Count;
    logic        i_Active;
    logic        i_Wr_En;
    logic [4:0]  i_Wr_X;
    logic [3:0]  i_Wr_Y;
    logic [15:0] i_Wr_Data;
    logic        i_Clear;
    logic [4:0]  o_X;
    logic [3:0]  o_Y;
    logic [15:0] o_Sprite;
    logic [4:0]  o_Local_X;
    logic [4:0]  o_Local_Y;
    logic        o_Valid;
    logic        o_Busy;
    logic        o_Wr_Err;

    always #5 i_Clk = ~i_Clk;

    tile_fetch dut (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_Col_Count (i_Col_Count),
        .i_Row_Count (i_Row_Count),
        .i_Active    (i_Active),
        .i_Wr_En     (i_Wr_En),
        .i_Wr_X      (i_Wr_X),
        .i_Wr_Y      (i_Wr_Y),
        .i_Wr_Data   (i_Wr_Data),
        .i_Clear     (i_Clear),
        .o_X         (o_X),
        .o_Y         (o_Y),
        .o_Sprite    (o_Sprite),
        .o_Local_X   (o_Local_X),
        .o_Local_Y   (o_Local_Y),
        .o_Valid     (o_Valid),
        .o_Busy      (o_Busy),
        .o_Wr_Err    (o_Wr_Err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference map, indexed by row*20 + col.
    logic [15:0] model_ram [0:299];

    typedef struct {
        int          col;
        int          row;
        logic [4:0]  x;
        logic [3:0]  y;
        logic [4:0]  lx;
        logic [4:0]  ly;
        logic        vld;
        logic [15:0] spr;
    } exp_t;

    task automatic tick();
        @(negedge i_Clk);
    endtask

    // Reference for one pixel: tile = position / tile size, offset = remainder.
    function automatic exp_t ref_pixel(input int col, input int row, input bit act);
        exp_t e;
        e.col = col;
        e.row = row;
        e.x   = 5'(col / 32);
        e.y   = 4'((row / 32) % 16);
        e.lx  = 5'(col % 32);
        e.ly  = 5'(row % 32);
        e.vld = act && (col < 640) && (row < 480);
        e.spr = e.vld ? model_ram[(row / 32) * 20 + (col / 32)] : 16'h0000;
        return e;
    endfunction

    task automatic drive_pixel(input int col, input int row, input bit act);
        i_Col_Count = 10'(col);
        i_Row_Count = 10'(row);
        i_Active    = act;
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_pixel($urandom_range(0, 799), $urandom_range(0, 524), 1'b1);
            i_Wr_Data = 16'($urandom);
            tick();
            n_checks++; if (o_Valid  !== 1'b0)  begin n_errors++; $display("FAIL reset_valid cyc %0d got %b want 0", c, o_Valid); end
            n_checks++; if (o_Sprite !== 16'h0) begin n_errors++; $display("FAIL reset_sprite cyc %0d got %h want 0", c, o_Sprite); end
            n_checks++; if (o_X      !== 5'd0)  begin n_errors++; $display("FAIL reset_x cyc %0d got %0d want 0", c, o_X); end
            n_checks++; if (o_Y      !== 4'd0)  begin n_errors++; $display("FAIL reset_y cyc %0d got %0d want 0", c, o_Y); end
            n_checks++; if (o_Local_X !== 5'd0) begin n_errors++; $display("FAIL reset_lx cyc %0d got %0d want 0", c, o_Local_X); end
            n_checks++; if (o_Local_Y !== 5'd0) begin n_errors++; $display("FAIL reset_ly cyc %0d got %0d want 0", c, o_Local_Y); end
            n_checks++; if (o_Busy   !== 1'b0)  begin n_errors++; $display("FAIL reset_busy cyc %0d got %b want 0", c, o_Busy); end
            n_checks++; if (o_Wr_Err !== 1'b0)  begin n_errors++; $display("FAIL reset_wrerr cyc %0d got %b want 0", c, o_Wr_Err); end
            $display("reset cycle %0d checked", c);
        end
        i_Rst_n = 1'b1;
        tick();
    endtask

    // Fill with 1, count busy cycles, poke a write and a second clear mid-sweep.
    task automatic test_clear();
        int cnt;
        i_Clear   = 1'b1;
        i_Wr_Data = 16'h0001;
        tick();
        i_Clear   = 1'b0;
        i_Wr_Data = 16'($urandom);   // fill value must have been captured already
        cnt = 0;
        while (o_Busy === 1'b1 && cnt < 400) begin
            if (cnt == 10) begin
                i_Wr_En = 1'b1; i_Wr_X = 5'd1; i_Wr_Y = 4'd1; i_Wr_Data = 16'hBEEF;
            end
            if (cnt == 11) begin
                n_checks++; if (o_Wr_Err !== 1'b1) begin n_errors++; $display("FAIL clear_write_rejected got %b want 1", o_Wr_Err); end
                i_Wr_En = 1'b0;
            end
            if (cnt == 20) begin i_Clear = 1'b1; i_Wr_Data = 16'h00AA; end
            if (cnt == 21) i_Clear = 1'b0;
            cnt++;
            tick();
        end
        n_checks++; if (cnt != 300) begin n_errors++; $display("FAIL clear_busy_cycles got %0d want 300", cnt); end
        $display("clear sweep: busy for %0d cycles", cnt);
        for (int a = 0; a < 300; a++) model_ram[a] = 16'h0001;
        begin
            int tiles [3][2] = '{'{0, 0}, '{19, 14}, '{10, 7}};
            for (int t = 0; t < 3; t++) begin
                drive_pixel(tiles[t][0] * 32 + 7, tiles[t][1] * 32 + 9, 1'b1);
                tick(); tick();
                n_checks++; if (o_Sprite !== 16'h0001 || o_Valid !== 1'b1) begin
                    n_errors++; $display("FAIL clear_tile (%0d,%0d) got sprite %h valid %b want 0001 1", tiles[t][0], tiles[t][1], o_Sprite, o_Valid);
                end
                $display("clear tile (%0d,%0d) sprite %h", tiles[t][0], tiles[t][1], o_Sprite);
            end
        end
    endtask

    // Scan every tile back to back and compare against the model.
    task automatic test_full_map(input string tag);
        exp_t q[$];
        exp_t e;
        int   bad = 0;
        for (int t = 0; t <= 300; t++) begin
            if (t < 300) begin
                drive_pixel((t % 20) * 32 + $urandom_range(0, 31), (t / 20) * 32 + $urandom_range(0, 31), 1'b1);
                q.push_back(ref_pixel(int'(i_Col_Count), int'(i_Row_Count), 1'b1));
            end
            tick();
            if (t >= 1) begin
                e = q.pop_front();
                n_checks++;
                if (o_Sprite !== e.spr || o_Valid !== 1'b1 || o_X !== e.x || o_Y !== e.y) begin
                    n_errors++; bad++;
                    $display("FAIL %s tile (%0d,%0d) got sprite %h valid %b xy %0d,%0d want %h 1 %0d,%0d",
                             tag, e.x, e.y, o_Sprite, o_Valid, o_X, o_Y, e.spr, e.x, e.y);
                end
            end
        end
        $display("%s: 300 tiles scanned, %0d bad", tag, bad);
    endtask

    task automatic test_write_scan();
        i_Wr_En = 1'b1; i_Wr_X = 5'd3; i_Wr_Y = 4'd2; i_Wr_Data = 16'h0002;
        tick();
        i_Wr_En = 1'b0;
        n_checks++; if (o_Wr_Err !== 1'b0) begin n_errors++; $display("FAIL write_scan_err got %b want 0", o_Wr_Err); end
        model_ram[2 * 20 + 3] = 16'h0002;
        drive_pixel(100, 70, 1'b1);
        tick(); tick();
        n_checks++; if (o_X !== 5'd3)          begin n_errors++; $display("FAIL write_scan_x got %0d want 3", o_X); end
        n_checks++; if (o_Y !== 4'd2)          begin n_errors++; $display("FAIL write_scan_y got %0d want 2", o_Y); end
        n_checks++; if (o_Local_X !== 5'd4)    begin n_errors++; $display("FAIL write_scan_lx got %0d want 4", o_Local_X); end
        n_checks++; if (o_Local_Y !== 5'd6)    begin n_errors++; $display("FAIL write_scan_ly got %0d want 6", o_Local_Y); end
        n_checks++; if (o_Sprite !== 16'h0002) begin n_errors++; $display("FAIL write_scan_sprite got %h want 0002", o_Sprite); end
        n_checks++; if (o_Valid !== 1'b1)      begin n_errors++; $display("FAIL write_scan_valid got %b want 1", o_Valid); end
        $display("write (3,2)=0002, scan (100,70): x %0d y %0d lx %0d ly %0d sprite %h", o_X, o_Y, o_Local_X, o_Local_Y, o_Sprite);
    endtask

    task automatic test_bounds();
        // X=20 would alias onto tile (0,1) if it slipped through.
        i_Wr_En = 1'b1; i_Wr_X = 5'd20; i_Wr_Y = 4'd0; i_Wr_Data = 16'hDEAD;
        tick();
        i_Wr_En = 1'b0;
        n_checks++; if (o_Wr_Err !== 1'b1) begin n_errors++; $display("FAIL bounds_x20_err got %b want 1", o_Wr_Err); end
        tick();
        n_checks++; if (o_Wr_Err !== 1'b0) begin n_errors++; $display("FAIL bounds_err_pulse got %b want 0", o_Wr_Err); end
        i_Wr_En = 1'b1; i_Wr_X = 5'd0; i_Wr_Y = 4'd15; i_Wr_Data = 16'hDEAD;
        tick();
        i_Wr_En = 1'b0;
        n_checks++; if (o_Wr_Err !== 1'b1) begin n_errors++; $display("FAIL bounds_y15_err got %b want 1", o_Wr_Err); end
        drive_pixel(5, 40, 1'b1);
        tick(); tick();
        n_checks++; if (o_Sprite !== model_ram[20]) begin n_errors++; $display("FAIL bounds_alias_tile01 got %h want %h", o_Sprite, model_ram[20]); end
        $display("bounds: rejected writes, tile (0,1) sprite %h", o_Sprite);
        begin
            int pts [3][3] = '{'{640, 10, 1}, '{10, 480, 1}, '{100, 70, 0}};
            exp_t e;
            for (int p = 0; p < 3; p++) begin
                drive_pixel(pts[p][0], pts[p][1], pts[p][2] != 0);
                e = ref_pixel(pts[p][0], pts[p][1], pts[p][2] != 0);
                tick(); tick();
                n_checks++; if (o_Valid !== 1'b0 || o_Sprite !== 16'h0000) begin
                    n_errors++; $display("FAIL bounds_invisible (%0d,%0d,%0d) got valid %b sprite %h want 0 0000", pts[p][0], pts[p][1], pts[p][2], o_Valid, o_Sprite);
                end
                n_checks++; if (o_X !== e.x || o_Y !== e.y) begin
                    n_errors++; $display("FAIL bounds_slice (%0d,%0d) got %0d,%0d want %0d,%0d", pts[p][0], pts[p][1], o_X, o_Y, e.x, e.y);
                end
                $display("invisible pixel (%0d,%0d,act %0d): valid %b x %0d", pts[p][0], pts[p][1], pts[p][2], o_Valid, o_X);
            end
        end
    endtask

    task automatic test_collision();
        i_Wr_En = 1'b1; i_Wr_X = 5'd5; i_Wr_Y = 4'd5; i_Wr_Data = 16'h0000;
        tick();
        i_Wr_En = 1'b0;
        model_ram[105] = 16'h0000;
        // The RAM read for this pixel happens on the second edge; the write
        // below is timed to land on that same edge.
        drive_pixel(161, 162, 1'b1);
        tick();
        i_Wr_En = 1'b1; i_Wr_X = 5'd5; i_Wr_Y = 4'd5; i_Wr_Data = 16'h0003;
        tick();
        i_Wr_En = 1'b0;
        n_checks++; if (o_Sprite !== 16'h0000) begin n_errors++; $display("FAIL collision_old got %h want 0000", o_Sprite); end
        model_ram[105] = 16'h0003;
        tick();
        n_checks++; if (o_Sprite !== 16'h0003) begin n_errors++; $display("FAIL collision_new got %h want 0003", o_Sprite); end
        $display("collision (5,5): next read %h", o_Sprite);
    endtask

    task automatic test_random_writes();
        int x, y;
        logic [15:0] d;
        bit exp_err;
        for (int k = 0; k < 40; k++) begin
            x = $urandom_range(0, 23);
            y = $urandom_range(0, 15);
            d = 16'($urandom);
            i_Wr_En = 1'b1; i_Wr_X = 5'(x); i_Wr_Y = 4'(y); i_Wr_Data = d;
            tick();
            exp_err = !(x < 20 && y < 15);
            n_checks++; if (o_Wr_Err !== exp_err) begin n_errors++; $display("FAIL rand_write (%0d,%0d) err got %b want %b", x, y, o_Wr_Err, exp_err); end
            if (!exp_err) model_ram[y * 20 + x] = d;
            $display("write (%0d,%0d)=%h err %b", x, y, d, o_Wr_Err);
        end
        i_Wr_En = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        for (int t = 0; t <= 60; t++) begin
            if (t < 60) begin
                drive_pixel($urandom_range(0, 799), $urandom_range(0, 524), ($urandom_range(0, 3) != 0));
                q.push_back(ref_pixel(int'(i_Col_Count), int'(i_Row_Count), i_Active));
            end
            tick();
            if (t >= 1) begin
                e = q.pop_front();
                n_checks++;
                if (o_X !== e.x || o_Y !== e.y || o_Local_X !== e.lx || o_Local_Y !== e.ly || o_Valid !== e.vld || o_Sprite !== e.spr) begin
                    n_errors++;
                    $display("FAIL b2b pixel (%0d,%0d) got x%0d y%0d lx%0d ly%0d v%b s%h want x%0d y%0d lx%0d ly%0d v%b s%h",
                             e.col, e.row, o_X, o_Y, o_Local_X, o_Local_Y, o_Valid, o_Sprite, e.x, e.y, e.lx, e.ly, e.vld, e.spr);
                end
                $display("pixel (%0d,%0d) -> tile %0d,%0d valid %b sprite %h", e.col, e.row, o_X, o_Y, o_Valid, o_Sprite);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [15:0] fill;
        fill = 16'($urandom);
        // Clear and write in the same IDLE cycle: clear wins.
        i_Clear = 1'b1; i_Wr_Data = fill;
        i_Wr_En = 1'b1; i_Wr_X = 5'd3; i_Wr_Y = 4'd13;
        tick();
        i_Clear = 1'b0; i_Wr_En = 1'b0; i_Wr_Data = ~fill;
        n_checks++; if (o_Wr_Err !== 1'b1) begin n_errors++; $display("FAIL clear_wins_err got %b want 1", o_Wr_Err); end
        n_checks++; if (o_Busy !== 1'b1)   begin n_errors++; $display("FAIL clear_start_busy got %b want 1", o_Busy); end
        repeat (150) tick();
        i_Rst_n = 1'b0;
        #1;
        n_checks++; if (o_Busy !== 1'b0)  begin n_errors++; $display("FAIL midclear_busy got %b want 0", o_Busy); end
        n_checks++; if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL midclear_valid got %b want 0", o_Valid); end
        $display("reset after 150 sweep cycles, fill %h", fill);
        tick();
        i_Rst_n = 1'b1;
        for (int a = 0; a < 150; a++) model_ram[a] = fill;
        tick();
        test_full_map("midclear_map");
    endtask

    initial begin
        i_Rst_n     = 1'b0;
        i_Col_Count = '0;
        i_Row_Count = '0;
        i_Active    = 1'b0;
        i_Wr_En     = 1'b0;
        i_Wr_X      = '0;
        i_Wr_Y      = '0;
        i_Wr_Data   = '0;
        i_Clear     = 1'b0;
        test_reset();
        test_clear();
        test_full_map("clear_map");
        test_write_scan();
        test_bounds();
        test_collision();
        test_random_writes();
        test_back_to_back();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
